// File: rtl/uart_tx_fifo.sv
// uart_tx_fifo: byte FIFO and launch controller feeding a UART transmitter.
// Ports:
//   clk, srst_n           clock (rising edge), async active-low reset
//   wr_en, wr_data        enqueue one byte per cycle
//   full, empty, level    occupancy; level excludes the byte presented on tx_data
//   overflow, ovf_clr     sticky drop flag and its clear (set wins over clear)
//   tx_start, tx_data     launch pulse and byte to the transmitter
//   tx_busy               transmitter busy
module uart_tx_fifo #(
  parameter int DEPTH = 16,
  parameter int AW    = 4
) (
  input  logic          clk,
  input  logic          srst_n,
  input  logic          wr_en,
  input  logic [7:0]    wr_data,
  output logic          full,
  output logic          empty,
  output logic [AW:0]   level,
  output logic          overflow,
  input  logic          ovf_clr,
  output logic          tx_start,
  output logic [7:0]    tx_data,
  input  logic          tx_busy
);
  typedef enum logic [1:0] {IDLE, LAUNCH, WAIT_ACK, WAIT_DONE} state_t;
  state_t r_state, w_next;
  logic [7:0]    r_mem [DEPTH];
  logic [AW-1:0] r_wr_ptr, r_rd_ptr;
  logic [AW:0]   r_level;
  logic [7:0]    r_tx_data;
  logic          r_ovf;
  logic          w_push, w_pop;
  assign full     = r_level == (AW+1)'(DEPTH);
  assign empty    = r_level == '0;
  assign level    = r_level;
  assign overflow = r_ovf;
  assign tx_data  = r_tx_data;
  assign tx_start = r_state == LAUNCH;
  // full/empty are pre-update, so a same-cycle pop never rescues a write
  // and a same-cycle write into an empty FIFO is not popped.
  assign w_push = wr_en && !full;
  always_comb begin
    w_pop  = (r_state == IDLE) && !empty && !tx_busy;
    w_next = w_pop                                  ? LAUNCH    :
             (r_state == LAUNCH)                    ? WAIT_ACK  :
             (r_state == WAIT_ACK  &&  tx_busy)     ? WAIT_DONE :
             (r_state == WAIT_DONE && !tx_busy)     ? IDLE      : r_state;
  end
  always_ff @(posedge clk) begin
    if (w_push) r_mem[r_wr_ptr] <= wr_data;
  end
  always_ff @(posedge clk or negedge srst_n) begin
    if (!srst_n) begin
      r_state   <= IDLE;
      r_wr_ptr  <= '0;
      r_rd_ptr  <= '0;
      r_level   <= '0;
      r_tx_data <= 8'h00;
      r_ovf     <= 1'b0;
    end else begin
      r_state <= w_next;
      r_level <= r_level + (AW+1)'(w_push) - (AW+1)'(w_pop);
      if (w_push) r_wr_ptr <= r_wr_ptr + AW'(1);
      if (w_pop) begin
        r_rd_ptr  <= r_rd_ptr + AW'(1);
        r_tx_data <= r_mem[r_rd_ptr];
      end
      if (wr_en && full) r_ovf <= 1'b1;
      else if (ovf_clr)  r_ovf <= 1'b0;
    end
  end
endmodule

// File: tb/tb_uart_tx_fifo.sv
// tb_uart_tx_fifo: directed bench with a 1 bit/clk transmitter model.
module tb_uart_tx_fifo;
  localparam int DEPTH = 16;
  localparam int AW = 4;
  logic clk = 1'b0;
  logic srst_n, wr_en, ovf_clr, tx_busy, full, empty, overflow, tx_start;
  logic [7:0] wr_data, tx_data, tx_sh;
  logic [AW:0] level;
  logic [3:0] tx_cnt;
  logic busy_hold, line;
  int cyc = 0;
  int n_asrt = 0;
  int n_fail = 0;
  int viol = 0;
  int lvl_max = 0;
  int st_cyc[$];
  logic [7:0] st_dat[$];
  logic [7:0] rx[$];

  uart_tx_fifo #(.DEPTH(DEPTH), .AW(AW)) dut (
    .clk(clk), .srst_n(srst_n), .wr_en(wr_en), .wr_data(wr_data),
    .full(full), .empty(empty), .level(level), .overflow(overflow),
    .ovf_clr(ovf_clr), .tx_start(tx_start), .tx_data(tx_data), .tx_busy(tx_busy)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  // Transmitter: START in the cycle after tx_start, 8 data bits LSB first, STOP.
  // The byte is latched one cycle after the launch pulse.
  always_ff @(posedge clk or negedge srst_n) begin
    if (!srst_n) begin
      tx_cnt <= 4'd0;
      tx_sh  <= 8'h00;
    end else if (tx_start && tx_cnt == 4'd0) begin
      tx_cnt <= 4'd10;
    end else if (tx_cnt != 4'd0) begin
      if (tx_cnt == 4'd10) tx_sh <= tx_data;
      tx_cnt <= tx_cnt - 4'd1;
    end
  end
  assign tx_busy = (tx_cnt != 4'd0) || busy_hold;
  always_comb begin
    line = 1'b1;
    if (tx_cnt == 4'd10) line = 1'b0;
    else if (tx_cnt >= 4'd2 && tx_cnt <= 4'd9) line = tx_sh[3'(4'd9 - tx_cnt)];
  end

  always @(negedge clk) begin
    if (tx_start) begin
      st_cyc.push_back(cyc);
      st_dat.push_back(tx_data);
      if (tx_busy) viol++;
    end
    if (tx_cnt == 4'd10) rx.push_back(tx_data);
    if (int'(level) > lvl_max) lvl_max = int'(level);
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_asrt++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic clr_logs();
    st_cyc.delete();
    st_dat.delete();
    rx.delete();
    lvl_max = 0;
  endtask

  task automatic wait_rx(input int n, input int budget);
    int k = 0;
    while (rx.size() < n && k < budget) begin
      tick();
      k++;
    end
    repeat (14) tick();
  endtask

  task automatic chk_idle(input string tag);
    chk({tag, "_empty"}, 32'(empty), 32'd1);
    chk({tag, "_full"}, 32'(full), 32'd0);
    chk({tag, "_level"}, 32'(level), 32'd0);
    chk({tag, "_start"}, 32'(tx_start), 32'd0);
    chk({tag, "_data"}, 32'(tx_data), 32'h00);
    chk({tag, "_ovf"}, 32'(overflow), 32'd0);
  endtask

  initial begin
    int c0, j, budget;
    logic [8:0] bits;
    srst_n = 1'b0; wr_en = 1'b0; wr_data = 8'h00; ovf_clr = 1'b0; busy_hold = 1'b0;
    repeat (2) tick();
    chk_idle("rst");
    srst_n = 1'b1;
    tick();
    chk_idle("idle");

    clr_logs();
    wr_en = 1'b1; wr_data = 8'hA5; c0 = cyc;
    tick();
    wr_en = 1'b0;
    chk("single_lvl1", 32'(level), 32'd1);
    chk("single_nostart", 32'(tx_start), 32'd0);
    tick();
    chk("single_start", 32'(tx_start), 32'd1);
    chk("single_data_l", 32'(tx_data), 32'hA5);
    chk("single_lvl0", 32'(level), 32'd0);
    tick();
    chk("single_start_off", 32'(tx_start), 32'd0);
    chk("single_data_n", 32'(tx_data), 32'hA5);
    for (int i = 0; i < 9; i++) begin
      bits[i] = line;
      tick();
    end
    chk("single_line", 32'(bits), 32'h14A);
    repeat (4) tick();
    chk("single_pulses", st_cyc.size(), 1);
    chk("single_lat", 32'(st_cyc[0] - c0), 32'd2);
    chk("single_rx", 32'(rx[0]), 32'hA5);
    chk("single_empty", 32'(empty), 32'd1);

    wr_en = 1'b1; wr_data = 8'h3C;
    tick();
    wr_data = 8'hC3;
    tick();
    wr_en = 1'b0;
    repeat (5) tick();
    #3 srst_n = 1'b0;
    #1;
    chk_idle("arst");
    tick();
    srst_n = 1'b1;
    clr_logs();
    repeat (20) tick();
    chk("arst_nolaunch", st_cyc.size(), 0);

    clr_logs();
    for (int i = 0; i < 4; i++) begin
      wr_en = 1'b1; wr_data = 8'(i + 1);
      tick();
    end
    wr_en = 1'b0;
    wait_rx(4, 100);
    chk("burst_cnt", st_cyc.size(), 4);
    for (int i = 0; i < 3; i++) chk("burst_period", 32'(st_cyc[i+1] - st_cyc[i]), 32'd13);
    for (int i = 0; i < 4; i++) chk("burst_data", 32'(rx[i]), 32'(i + 1));
    chk("burst_peak", 32'(lvl_max), 32'd3);

    clr_logs();
    busy_hold = 1'b1;
    for (int i = 0; i <= DEPTH; i++) begin
      wr_en = 1'b1; wr_data = 8'h40 + 8'(i);
      tick();
      if (i == DEPTH - 1) begin
        chk("ovf_full16", 32'(full), 32'd1);
        chk("ovf_lvl16", 32'(level), 32'd16);
        chk("ovf_not_yet", 32'(overflow), 32'd0);
      end
    end
    wr_en = 1'b0;
    chk("ovf_set", 32'(overflow), 32'd1);
    chk("ovf_lvl_hold", 32'(level), 32'd16);
    ovf_clr = 1'b1;
    tick();
    ovf_clr = 1'b0;
    chk("ovf_clr", 32'(overflow), 32'd0);
    busy_hold = 1'b0;
    wait_rx(DEPTH, 300);
    chk("ovf_rx_cnt", rx.size(), DEPTH);
    chk("ovf_pulses", st_cyc.size(), DEPTH);
    for (int i = 0; i < DEPTH; i++) chk("ovf_rx_data", 32'(rx[i]), 32'h40 + 32'(i));
    chk("ovf_drained", 32'(empty), 32'd1);

    clr_logs();
    busy_hold = 1'b1;
    for (int i = 0; i < DEPTH; i++) begin
      wr_en = 1'b1; wr_data = 8'h60 + 8'(i);
      tick();
    end
    busy_hold = 1'b0; wr_en = 1'b1; wr_data = 8'hEE;
    tick();
    wr_en = 1'b0;
    chk("fpop_ovf", 32'(overflow), 32'd1);
    chk("fpop_lvl", 32'(level), 32'd15);
    chk("fpop_notfull", 32'(full), 32'd0);
    ovf_clr = 1'b1;
    tick();
    ovf_clr = 1'b0;
    wait_rx(DEPTH, 300);
    chk("fpop_rx_cnt", rx.size(), DEPTH);
    for (int i = 0; i < DEPTH; i++) chk("fpop_rx_data", 32'(rx[i]), 32'h60 + 32'(i));

    clr_logs();
    busy_hold = 1'b1;
    for (int i = 0; i < 5; i++) begin
      wr_en = 1'b1; wr_data = 8'h80 + 8'(i);
      tick();
    end
    wr_en = 1'b0;
    chk("wp_lvl5_pre", 32'(level), 32'd5);
    busy_hold = 1'b0; wr_en = 1'b1; wr_data = 8'h85;
    tick();
    wr_en = 1'b0;
    chk("wp_lvl5_post", 32'(level), 32'd5);
    chk("wp_start", 32'(tx_start), 32'd1);
    j = 6; budget = 0;
    while (j < 3 * DEPTH && budget < 1000) begin
      if (!full) begin
        wr_en = 1'b1; wr_data = 8'h80 + 8'(j); j++;
      end else wr_en = 1'b0;
      tick();
      budget++;
    end
    wr_en = 1'b0;
    wait_rx(3 * DEPTH, 900);
    chk("wrap_rx_cnt", rx.size(), 3 * DEPTH);
    for (int i = 0; i < 3 * DEPTH; i++) chk("wrap_rx_data", 32'(rx[i]), 32'h80 + 32'(i));
    chk("wrap_pulses", st_cyc.size(), 3 * DEPTH);
    chk("wrap_idle_empty", 32'(empty), 32'd1);
    chk("no_start_while_busy", 32'(viol), 32'd0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_asrt, n_fail);
    $finish;
  end
endmodule

// File: doc/uart_tx_fifo.md
Name: uart_tx_fifo

Overview:
Byte FIFO and launch controller sitting directly upstream of the UART transmitter. It buffers bytes written by the core/bus side and presents them one at a time on the transmitter's start/in/busy interface. It honours the transmitter's one-cycle-delayed data capture and waits for each frame to complete before launching the next.

Parameters:
DEPTH, 16, FIFO entries; must be a power of two, minimum 2
AW, 4, pointer width, log2(DEPTH)

Ports:
clk  input  1  clock; all logic on rising edge
srst_n  input  1  reset; asynchronous assert, active-low; clears all state
wr_en  input  1  write strobe, one byte per cycle when high
wr_data  input  8  byte to enqueue
full  output  1  level == DEPTH
empty  output  1  level == 0
level  output  AW+1  bytes currently stored, excluding the byte on tx_data
overflow  output  1  sticky: a write was dropped while full
ovf_clr  input  1  clears overflow
tx_start  output  1  launch pulse to transmitter start
tx_data  output  8  byte to transmitter in; held stable until next pop
tx_busy  input  1  transmitter busy

Behaviour:
- Reset (srst_n low, any time, async): state=IDLE, rd/wr pointers=0, level=0, tx_start=0, tx_data=8'h00, overflow=0, full=0, empty=1. Storage array is not reset. Reset mid-frame abandons the byte in flight; no retry.
- Storage: DEPTH x 8 circular buffer; wr_ptr/rd_ptr are AW bits and wrap modulo DEPTH. level counter is AW+1 bits.
- Write: wr_en && !full -> mem[wr_ptr]<=wr_data, wr_ptr++, level++. wr_en && full -> byte dropped, overflow<=1, no pointer change. full is evaluated on the current level; a pop in the same cycle does NOT rescue the write.
- overflow: set has priority over ovf_clr in the same cycle.
- Launch FSM (registered state, 2 bits):
  IDLE: if !empty && !tx_busy -> tx_data<=mem[rd_ptr], rd_ptr++, level--, go LAUNCH; else stay.
  LAUNCH: tx_start=1 for exactly this cycle; go WAIT_ACK.
  WAIT_ACK: wait for tx_busy=1 (transmitter capturing tx_data), then go WAIT_DONE; stay otherwise.
  WAIT_DONE: wait for tx_busy=0 (frame finished), then go IDLE.
- tx_start is decoded from registered state only (glitch-free), high only in LAUNCH.
- tx_data changes only on a pop; it is stable in the LAUNCH cycle and the following cycle, when the transmitter latches it.
- Simultaneous write and pop: both take effect, level unchanged; writing into an empty FIFO the same cycle IDLE evaluates does not pop that byte (empty is pre-write).
- Timing with the companion transmitter (1 bit/clk): byte written in cycle 0 on an idle, empty system -> pop in cycle 1, tx_start in cycle 2, transmitter START in 3, DATA in 4-11, STOP in 12, busy low in 13, FSM IDLE in 14, next pop in 14, next tx_start in 15. Back-to-back frame period = 13 cycles.
- level/full/empty reflect registered counts; the byte on tx_data is not counted.
- Throughput limit: the FIFO never issues tx_start while tx_busy=1.

Test Plan:
- Reset then idle -> empty=1, full=0, level=0, tx_start=0, tx_data=8'h00, overflow=0; assert srst_n low mid-frame -> all outputs return to these values immediately, without waiting for a clock edge.
- Single write 8'hA5 with transmitter idle -> exactly one tx_start pulse 2 cycles later, tx_data=8'hA5 in that cycle and the next, serial line shows 0,1,0,1,0,0,1,0,1, level back to 0.
- Burst write 8'h01..8'h04 in consecutive cycles -> four frames in order, tx_start pulses 13 cycles apart, level peaks at 3.
- Write DEPTH+1 bytes while tx_busy held high -> full=1 after DEPTH writes, last byte dropped, overflow=1; pulse ovf_clr -> overflow=0; release tx_busy -> DEPTH frames delivered in order with no duplicates.
- With level=DEPTH and the FSM popping in the same cycle as wr_en -> write dropped, overflow=1, level=DEPTH-1.
- Write and pop in the same cycle at level=5 -> level stays 5; the pointer wrap after 3*DEPTH bytes preserves order.
